// File: rtl/johnson_step_counter_if.sv
// Control and status bundle for johnson_step_counter.
// The master drives step/load controls; the slave returns the Johnson code and status.
interface johnson_step_counter_if;
  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] j;
  logic [2:0] idx;
  logic       tc;
  logic       err;

  modport master (
    output en, dir, load, load_val,
    input  j, idx, tc, err
  );

  modport slave (
    input  en, dir, load, load_val,
    output j, idx, tc, err
  );
endinterface

// File: rtl/johnson_step_counter.sv
// 4-bit up/down Johnson counter with preset load, sequence index, wrap pulse and error flag.
// Define JOHNSON_SELF_CORRECT_EN to force illegal codes back to 0000 with a one-cycle err pulse.
module johnson_step_counter (
  input  logic                         clk,
  input  logic                         rst_n,
  johnson_step_counter_if.slave        ctr
);

  // Returns {legal, position} for a 4-bit code.
  function automatic logic [3:0] decode(input logic [3:0] code);
    logic [3:0] res;
    case (code)
      4'b0000: res = {1'b1, 3'd0};
      4'b0001: res = {1'b1, 3'd1};
      4'b0011: res = {1'b1, 3'd2};
      4'b0111: res = {1'b1, 3'd3};
      4'b1111: res = {1'b1, 3'd4};
      4'b1110: res = {1'b1, 3'd5};
      4'b1100: res = {1'b1, 3'd6};
      4'b1000: res = {1'b1, 3'd7};
      default: res = {1'b0, 3'd0};
    endcase
    return res;
  endfunction

  logic [3:0] j_q, j_d;
  logic [2:0] idx_q, idx_d;
  logic       tc_q, tc_d;
  logic [3:0] load_dec;
  logic [3:0] j_up, j_down;

  assign load_dec = decode(ctr.load_val);
  assign j_up     = {j_q[2:0], ~j_q[3]};
  assign j_down   = {~j_q[0], j_q[3:1]};

`ifdef JOHNSON_SELF_CORRECT_EN
  logic       err_q, err_d;
  logic [3:0] j_dec;
  logic       j_legal;

  assign j_dec   = decode(j_q);
  assign j_legal = j_dec[3];
`endif

  always_comb begin
    j_d   = j_q;
    idx_d = idx_q;
    tc_d  = 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
    err_d = 1'b0;
`endif
    if (ctr.load) begin
      j_d   = ctr.load_val;
      idx_d = load_dec[3] ? load_dec[2:0] : 3'd0;
`ifdef JOHNSON_SELF_CORRECT_EN
    end else if (!j_legal) begin
      // Recovery takes precedence over stepping and never produces a wrap pulse.
      j_d   = 4'b0000;
      idx_d = 3'd0;
      err_d = 1'b1;
`endif
    end else if (ctr.en) begin
      if (ctr.dir) begin
        j_d   = j_up;
        idx_d = idx_q + 3'd1;
        tc_d  = (idx_q == 3'd7);
      end else begin
        j_d   = j_down;
        idx_d = idx_q - 3'd1;
        tc_d  = (idx_q == 3'd0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q   <= 4'b0000;
      idx_q <= 3'd0;
      tc_q  <= 1'b0;
`ifdef JOHNSON_SELF_CORRECT_EN
      err_q <= 1'b0;
`endif
    end else begin
      j_q   <= j_d;
      idx_q <= idx_d;
      tc_q  <= tc_d;
`ifdef JOHNSON_SELF_CORRECT_EN
      err_q <= err_d;
`endif
    end
  end

  assign ctr.j   = j_q;
  assign ctr.idx = idx_q;
  assign ctr.tc  = tc_q;
`ifdef JOHNSON_SELF_CORRECT_EN
  assign ctr.err = err_q;
`else
  assign ctr.err = 1'b0;
`endif

endmodule
